// File: rtl/fpga_out_channel.sv
// Output channel between the program executor and a consumer.
// A circular-buffer FIFO collects executor words. A small FSM flushes the
// remaining words after the executor's last pulse and then reports drained.
module fpga_out_channel #(
  parameter int MemoryElementWidth = 12,
  parameter int NOut               = 8,
  parameter int TotalWidth         = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [MemoryElementWidth-1:0] in_data,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MemoryElementWidth-1:0] out_data,
  output logic [$clog2(NOut+1)-1:0]     level,
  output logic [TotalWidth-1:0]         total,
  output logic                          overflow,
  output logic                          drained
);

  localparam int LW = $clog2(NOut+1);
  localparam int PW = $clog2(NOut);

  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

  state_t                        state;
  logic [MemoryElementWidth-1:0] mem [NOut];
  logic [PW-1:0]                 wptr, rptr;
  logic                          push, pop, full, run_wr;

  // Pointer advance with wrap from NOut-1 back to 0 (NOut need not be a power of two).
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(NOut-1)) ? '0 : p + 1'b1;
  endfunction

  // The head comes straight from storage. No write-to-read bypass exists, so a
  // pushed word is first visible after its write edge.
  assign out_valid = (level != '0) && (state != DONE);
  assign out_data  = mem[rptr];
  assign pop       = out_valid && out_ready;
  assign full      = (level == LW'(NOut));
  assign run_wr    = in_valid && (state == RUN);
  // A full FIFO still takes a word when the head leaves on the same edge.
  assign push      = run_wr && (!full || pop);

  // Storage write. The contents are left uncleared on reset; only the pointers define validity.
  always_ff @(posedge clock) begin
    if (push) mem[wptr] <= in_data;
  end

  // Read/write pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= nxt(wptr);
      if (pop)  rptr <= nxt(rptr);
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Saturating accepted-word count and sticky drop flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      total    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push && (total != '1)) total <= total + 1'b1;
      if (run_wr && !push)       overflow <= 1'b1;
    end
  end

  // Run/flush/done sequencing. Drained is registered alongside the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= RUN;
      drained <= 1'b0;
    end else begin
      case (state)
        RUN:     if (in_last) state <= FLUSH;
        FLUSH:   if (level == '0) begin
                   state   <= DONE;
                   drained <= 1'b1;
                 end
        DONE:    state <= DONE;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: doc/fpga_out_channel.md
FPGA_OUT_CHANNEL -- requirements
Module: fpga_out_channel

Interface
REQ-001 Parameter MemoryElementWidth, default 12, is the width of each out-channel word.
REQ-002 Parameter NOut, default 8, is the FIFO depth in words; legal range 2..256.
REQ-003 Parameter TotalWidth, default 16, is the width of the accepted-word counter.
REQ-004 clock  input  1  sole clock; all state changes on posedge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  program executor writes one out word this cycle.
REQ-007 in_data  input  MemoryElementWidth  word written by the executor.
REQ-008 in_last  input  1  single-cycle pulse: executor program has finished.
REQ-009 out_valid  output  1  head word available to the consumer.
REQ-010 out_ready  input  1  consumer accepts the head word this cycle.
REQ-011 out_data  output  MemoryElementWidth  head word; meaningful only while out_valid=1.
REQ-012 level  output  clog2(NOut+1)  current FIFO occupancy.
REQ-013 total  output  TotalWidth  count of words accepted into the FIFO since reset.
REQ-014 overflow  output  1  sticky: at least one word was dropped because the FIFO was full.
REQ-015 drained  output  1  program finished and every accepted word delivered.

Function
REQ-016 Storage is a circular buffer of NOut words with read and write pointers that wrap from NOut-1 to 0.
REQ-017 Push condition: in_valid=1, state RUN, and (level<NOut, or a pop occurs in the same cycle).
REQ-018 Pop condition: out_valid=1 and out_ready=1; the head advances on that clock edge.
REQ-019 out_valid = (level!=0) and state!=DONE; out_data is driven from the head entry with no combinational path from in_data.
REQ-020 Latency: a word pushed at edge t is visible on out_valid/out_data after edge t; there is no same-cycle bypass when the FIFO is empty.
REQ-021 A simultaneous push and pop leaves level unchanged, and both pointers advance.
REQ-022 Full, in_valid=1, no pop: the word is dropped, overflow is set to 1 and held until reset, and total is not incremented.
REQ-023 total increments by 1 on each push and saturates at all-ones.
REQ-024 FSM states: RUN, FLUSH, DONE.
REQ-025 RUN: pushes are accepted; in_last=1 moves the FSM to FLUSH, and an in_valid in the same cycle as in_last is still pushed.
REQ-026 FLUSH: in_valid is ignored (no push, no overflow, no total change) and pops continue; when level=0 after the edge, the FSM moves to DONE on the next edge.
REQ-027 DONE: drained=1, out_valid=0, and all inputs except reset are ignored; the FSM stays in DONE until reset.
REQ-028 drained = (state==DONE), registered.
REQ-029 With in_last at edge t and the FIFO empty with no push, the FSM is in FLUSH after t and in DONE (drained=1) after t+1.
REQ-030 in_last pulses received in FLUSH or DONE are ignored.
REQ-031 out_ready while out_valid=0 has no effect.

Reset
REQ-032 reset=1 at a posedge forces: state RUN, pointers 0, level 0, total 0, overflow 0, drained 0, out_valid 0.
REQ-033 Reset takes priority over a simultaneous push, pop or in_last; FIFO contents are discarded, and storage RAM need not be cleared.
REQ-034 Reset asserted mid-FLUSH or in DONE returns the block to RUN after the next edge, with all counters zero.

Verification
REQ-035 Push 2 then 1 with out_ready=1 -> out_data sequence 2,1, each valid one cycle after push; total=2, level back to 0.
REQ-036 NOut=8, out_ready=0, push 10 words 1..10 -> level=8, overflow=1, total=8; then drain -> outputs 1..8 in order.
REQ-037 Fill to 8, then hold in_valid=1 with out_ready=1 for 20 cycles -> level stays 8, no overflow, outputs in push order across pointer wrap.
REQ-038 in_last with the same-cycle push of 5 and 3 words queued, out_ready=1 -> all 4 words delivered, push attempts during FLUSH ignored, drained=1 one edge after empty.
REQ-039 in_last with an empty FIFO -> drained=0 after t, drained=1 after t+1; a later in_valid leaves total unchanged.
REQ-040 reset during FLUSH with level=3 -> the next cycle shows level=0, total=0, out_valid=0, drained=0, state RUN; a new push is accepted.
